// File: rtl/mano_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_pkg: shared state/opcode/register-reference encodings for the Mano core.
// Rev 1.0
// ----------------------------------------------------------------------------
package mano_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_INDIRECT = 3'd2,
    S_READ     = 3'd3,
    S_EXEC     = 3'd4,
    S_WRITE    = 3'd5,
    S_HALT     = 3'd6,
    S_INTR     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_ADD = 2'd1,
    ALU_LDA = 2'd2,
    ALU_REG = 2'd3
  } alu_op_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int B_CLA = 11;
  localparam int B_CLE = 10;
  localparam int B_CMA = 9;
  localparam int B_CME = 8;
  localparam int B_CIR = 7;
  localparam int B_CIL = 6;
  localparam int B_INC = 5;
  localparam int B_SPA = 4;
  localparam int B_SNA = 3;
  localparam int B_SZA = 2;
  localparam int B_SZE = 1;
  localparam int B_HLT = 0;
  localparam int B_ION = 7;
  localparam int B_IOF = 6;

  function automatic bit params_ok(input int dw, input int aw);
    return (dw >= 16) && (aw >= 1) && (aw <= dw - 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mano_mem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_mem_if: req/ack memory bus between the Mano core (master) and RAM (slave).
// Rev 1.0
// ----------------------------------------------------------------------------
interface mano_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mano_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_alu: combinational AC/E update for memory-ref ALU ops and register-ref ops.
// Rev 1.0
// ----------------------------------------------------------------------------
module mano_alu
  import mano_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_dr,
  input  logic              i_e,
  input  logic [B_CLA:B_INC] i_rr,
  output logic [DATA_W-1:0] o_ac,
  output logic              o_e
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_ac} + {1'b0, i_dr};

  // Register-ref bits chain in order so combined microops compose predictably.
  always_comb begin
    o_ac = i_ac;
    o_e  = i_e;
    case (i_op)
      ALU_AND: o_ac = i_ac & i_dr;
      ALU_ADD: {o_e, o_ac} = w_sum;
      ALU_LDA: o_ac = i_dr;
      default: begin
        if (i_rr[B_CLA]) o_ac = '0;
        if (i_rr[B_CLE]) o_e  = 1'b0;
        if (i_rr[B_CMA]) o_ac = ~o_ac;
        if (i_rr[B_CME]) o_e  = ~o_e;
        if (i_rr[B_CIR]) {o_ac, o_e} = {o_e, o_ac};
        if (i_rr[B_CIL]) {o_e, o_ac} = {o_ac, o_e};
        if (i_rr[B_INC]) o_ac = o_ac + 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mano_cpu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_cpu_core: multi-cycle Mano basic computer on a req/ack memory bus.
// Define MANO_INTR_EN for the IEN flip-flop, ION/IOF and the interrupt cycle.  Rev 1.0
// ----------------------------------------------------------------------------
module mano_cpu_core
  import mano_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  mano_mem_if.master        mem,
  input  logic              intr_req,
  output logic              halted,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic              e
);

  if (!params_ok(DATA_W, ADDR_W)) begin : g_bad_params
    $error("mano_cpu_core: need DATA_W >= 16 and ADDR_W <= DATA_W-4");
  end

  state_t            r_state, w_state_nxt, w_end_state;
  logic [DATA_W-1:0] r_ac, r_dr, r_ir;
  logic [ADDR_W-1:0] r_ar, r_pc;
  logic              r_e;
  logic              r_started;

  logic              w_mem_req, w_mem_we, w_ack;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata, w_pc_ext;
  logic              w_i, w_halt_op, w_skip;
  logic [2:0]        w_d;
  logic [11:0]       w_rr;
  alu_op_t           w_alu_op;
  logic [DATA_W-1:0] w_alu_ac;
  logic              w_alu_e;

  assign w_i       = r_ir[DATA_W-1];
  assign w_d       = r_ir[DATA_W-2 -: 3];
  assign w_rr      = r_ir[11:0];
  assign w_pc_ext  = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
  assign w_ack     = w_mem_req & mem.mem_ack;
  assign w_halt_op = (w_d == OP_REG) & ~w_i & w_rr[B_HLT];
  assign w_skip    = (w_rr[B_SPA] & ~r_ac[DATA_W-1]) | (w_rr[B_SNA] & r_ac[DATA_W-1]) |
                     (w_rr[B_SZA] & (r_ac == '0))    | (w_rr[B_SZE] & ~r_e);

  assign w_alu_op = (w_d == OP_AND) ? ALU_AND :
                    (w_d == OP_ADD) ? ALU_ADD :
                    (w_d == OP_LDA) ? ALU_LDA : ALU_REG;

  mano_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (w_alu_op),
    .i_ac (r_ac),
    .i_dr (r_dr),
    .i_e  (r_e),
    .i_rr (w_rr[B_CLA:B_INC]),
    .o_ac (w_alu_ac),
    .o_e  (w_alu_e)
  );

`ifdef MANO_INTR_EN
  logic r_ien;
  assign w_end_state = (r_ien & intr_req) ? S_INTR : S_FETCH;
`else
  logic w_unused_intr;
  assign w_unused_intr = intr_req;
  assign w_end_state   = S_FETCH;
`endif

  function automatic state_t route(input logic [2:0] d);
    case (d)
      OP_AND, OP_ADD, OP_LDA, OP_ISZ: route = S_READ;
      OP_STA, OP_BSA:                 route = S_WRITE;
      default:                        route = S_EXEC;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:    if (w_ack) w_state_nxt = S_DECODE;
      S_DECODE:   w_state_nxt = ((w_d != OP_REG) && w_i) ? S_INDIRECT : route(w_d);
      S_INDIRECT: if (w_ack) w_state_nxt = route(w_d);
      S_READ:     if (w_ack) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_d == OP_ISZ) w_state_nxt = S_WRITE;
        else if (w_halt_op) w_state_nxt = S_HALT;
        else w_state_nxt = w_end_state;
      end
      S_WRITE:    if (w_ack) w_state_nxt = w_end_state;
      S_INTR:     if (w_ack) w_state_nxt = S_FETCH;
      default:    w_state_nxt = S_HALT;
    endcase
  end

  // No request in the first cycle after reset, so a stale ack cannot land.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ar;
    w_mem_wdata = '0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_pc;
      end
      S_INDIRECT, S_READ: w_mem_req = 1'b1;
      S_WRITE: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_wdata = (w_d == OP_STA) ? r_ac : (w_d == OP_BSA) ? w_pc_ext : r_dr;
      end
      S_INTR: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = '0;
        w_mem_wdata = w_pc_ext;
      end
      default: ;
    endcase
    w_mem_req = w_mem_req & r_started;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ac      <= '0;
      r_dr      <= '0;
      r_ir      <= '0;
      r_ar      <= '0;
      r_pc      <= '0;
      r_e       <= 1'b0;
      r_started <= 1'b0;
`ifdef MANO_INTR_EN
      r_ien     <= 1'b0;
`endif
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_FETCH: if (w_ack) begin
          r_ir <= mem.mem_rdata;
          r_pc <= r_pc + 1'b1;
        end
        S_DECODE:   r_ar <= r_ir[ADDR_W-1:0];
        S_INDIRECT: if (w_ack) r_ar <= mem.mem_rdata[ADDR_W-1:0];
        S_READ:     if (w_ack) r_dr <= mem.mem_rdata;
        S_EXEC: begin
          case (w_d)
            OP_AND, OP_ADD, OP_LDA: begin
              r_ac <= w_alu_ac;
              r_e  <= w_alu_e;
            end
            OP_BUN: r_pc <= r_ar;
            OP_ISZ: r_dr <= r_dr + 1'b1;
            OP_REG: begin
              if (!w_i) begin
                r_ac <= w_alu_ac;
                r_e  <= w_alu_e;
                if (w_skip) r_pc <= r_pc + 1'b1;
              end
`ifdef MANO_INTR_EN
              else begin
                if (w_rr[B_ION]) r_ien <= 1'b1;
                if (w_rr[B_IOF]) r_ien <= 1'b0;
              end
`endif
            end
            default: ;
          endcase
        end
        S_WRITE: if (w_ack) begin
          if (w_d == OP_BSA) r_pc <= r_ar + 1'b1;
          else if ((w_d == OP_ISZ) && (r_dr == '0)) r_pc <= r_pc + 1'b1;
        end
        S_INTR: if (w_ack) begin
          r_pc <= {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef MANO_INTR_EN
          r_ien <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = w_mem_req;
  assign mem.mem_we    = w_mem_we;
  assign mem.mem_addr  = w_mem_addr;
  assign mem.mem_wdata = w_mem_wdata;

  assign halted = (r_state == S_HALT);
  assign ac     = r_ac;
  assign dr     = r_dr;
  assign ir     = r_ir;
  assign ar     = r_ar;
  assign pc     = r_pc;
  assign e      = r_e;

endmodule
`default_nettype wire

// File: tb/tb_mano_cpu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mano_cpu_core: directed programs against a wait-state RAM model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mano_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        intr_req = 1'b0;
  logic        halted, e;
  logic [15:0] ac, dr, ir;
  logic [11:0] ar, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mano_mem_if #(.DATA_W(16), .ADDR_W(12)) m_if ();

  mano_cpu_core #(.DATA_W(16), .ADDR_W(12)) dut (
    .CLK      (clk),
    .RST      (rst),
    .mem      (m_if.master),
    .intr_req (intr_req),
    .halted   (halted),
    .ac       (ac),
    .dr       (dr),
    .ir       (ir),
    .ar       (ar),
    .pc       (pc),
    .e        (e)
  );

  // RAM model: ack after ack_delay waiting cycles; force_ack injects a stray ack.
  logic [15:0] mem_arr [0:4095];
  int          ack_delay = 0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
  logic        clr = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  assign m_if.mem_ack   = force_ack | (m_if.mem_req && (cnt >= ack_delay));
  assign m_if.mem_rdata = mem_arr[m_if.mem_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= '0;
    end else if (ld_en) begin
      mem_arr[ld_addr] <= ld_data;
    end else if (m_if.mem_req && m_if.mem_ack && m_if.mem_we) begin
      mem_arr[m_if.mem_addr] <= m_if.mem_wdata;
    end
    if (m_if.mem_req && !m_if.mem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic prep();
    @(negedge clk);
    rst       = 1'b1;
    intr_req  = 1'b0;
    force_ack = 1'b0;
    clr       = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Releases reset and counts rising edges until HALT (or budget runs out).
  task automatic run(input int delay, input logic [15:0] watch, output int cyc_halt,
                     output int cyc_hit, output logic [11:0] ar_hit, output logic e_hit);
    ack_delay = delay;
    cyc_halt  = -1;
    cyc_hit   = -1;
    ar_hit    = '0;
    e_hit     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (cyc_hit < 0 && ac == watch) begin
        cyc_hit = n;
        ar_hit  = ar;
        e_hit   = e;
      end
      if (halted) begin
        cyc_halt = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    prep();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", pc); end
    checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL reset_ac: got %h want 0000", ac); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_e: got %b want 0", e); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (m_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", m_if.mem_req); end
  endtask

  task automatic test_reset_mid_access();
    prep();
    load(12'h000, 16'h7001);
    ack_delay = 100;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_if.mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pending: got %b want 1", m_if.mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    checks++; if (m_if.mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_after_rst: got %b want 0", m_if.mem_req); end
    @(negedge clk);
    force_ack = 1'b0;
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL mid_ir: got %h want 0000", ir); end
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL mid_pc: got %h want 000", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted: got %b want 0", halted); end
    rst = 1'b1;
  endtask

  task automatic test_lda_add();
    int c_h, c_w; logic [11:0] a_w; logic e_w;
    prep();
    load(12'd0, 16'h200A);
    load(12'd1, 16'h100B);
    load(12'd2, 16'h7001);
    load(12'd10, 16'hFFFF);
    load(12'd11, 16'h0001);
    run(0, 16'hABCD, c_h, c_w, a_w, e_w);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL add_halted: got %b want 1", halted); end
    checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL add_ac: got %h want 0000", ac); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL add_e: got %b want 1", e); end
    checks++; if (pc !== 12'h003) begin errors++; $display("FAIL add_pc: got %h want 003", pc); end
    checks++; if (c_h != 12) begin errors++; $display("FAIL add_cycles: got %0d want 12", c_h); end
  endtask

  task automatic test_indirect();
    int c_h0, c_w0, c_h3, c_w3; logic [11:0] a_w0, a_w3; logic e_w;
    prep();
    load(12'd0, 16'hA014);
    load(12'd1, 16'h7001);
    load(12'd20, 16'h0030);
    load(12'h030, 16'h1234);
    run(0, 16'h1234, c_h0, c_w0, a_w0, e_w);
    checks++; if (ac !== 16'h1234) begin errors++; $display("FAIL ind_ac: got %h want 1234", ac); end
    checks++; if (a_w0 !== 12'h030) begin errors++; $display("FAIL ind_ar: got %h want 030", a_w0); end
    checks++; if (c_w0 != 6) begin errors++; $display("FAIL ind_cycles0: got %0d want 6", c_w0); end
    prep();
    load(12'd0, 16'hA014);
    load(12'd1, 16'h7001);
    load(12'd20, 16'h0030);
    load(12'h030, 16'h1234);
    run(3, 16'h1234, c_h3, c_w3, a_w3, e_w);
    checks++; if (a_w3 !== 12'h030) begin errors++; $display("FAIL ind_ar_wait: got %h want 030", a_w3); end
    checks++; if (c_w3 != 15) begin errors++; $display("FAIL ind_cycles3: got %0d want 15", c_w3); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ind_halted: got %b want 1", halted); end
  endtask

  task automatic test_isz_bsa();
    int c_h, c_w; logic [11:0] a_w; logic e_w;
    prep();
    load(12'd0, 16'h6028);
    load(12'd1, 16'h7001);
    load(12'd2, 16'h4005);
    load(12'd5, 16'h5032);
    load(12'd51, 16'h7001);
    load(12'd40, 16'hFFFF);
    run(1, 16'hABCD, c_h, c_w, a_w, e_w);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL isz_halted: got %b want 1", halted); end
    checks++; if (mem_arr[40] !== 16'h0000) begin errors++; $display("FAIL isz_mem: got %h want 0000", mem_arr[40]); end
    checks++; if (mem_arr[50] !== 16'h0006) begin errors++; $display("FAIL bsa_mem: got %h want 0006", mem_arr[50]); end
    checks++; if (pc !== 12'd52) begin errors++; $display("FAIL bsa_pc: got %0d want 52", pc); end
  endtask

  task automatic test_regref();
    int c_h, c_w; logic [11:0] a_w; logic e_w;
    logic [15:0] prog [0:15];
    prog = '{16'h2020, 16'h7008, 16'h7001, 16'h7040, 16'h7C00, 16'h7200, 16'h7020, 16'h7100,
             16'h7002, 16'h7080, 16'h7010, 16'h7A20, 16'h7004, 16'h7001, 16'h7200, 16'h7001};
    prep();
    for (int i = 0; i < 16; i++) load(12'(i), prog[i]);
    load(12'h020, 16'h8001);
    run(0, 16'h0002, c_h, c_w, a_w, e_w);
    checks++; if (c_w < 0 || e_w !== 1'b1) begin errors++; $display("FAIL cil_result: hit %0d e %b want hit e=1", c_w, e_w); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reg_halted: got %b want 1", halted); end
    checks++; if (pc !== 12'd16) begin errors++; $display("FAIL reg_pc: got %0d want 16", pc); end
    checks++; if (ac !== 16'hFFFF) begin errors++; $display("FAIL reg_ac: got %h want ffff", ac); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL reg_e: got %b want 0", e); end
    checks++; if (c_h != 44) begin errors++; $display("FAIL reg_cycles: got %0d want 44", c_h); end
  endtask

  task automatic test_intr();
    int c_h, c_w; logic [11:0] a_w; logic e_w;
    prep();
    load(12'd0, 16'hF080);
    load(12'd1, 16'h7800);
    load(12'd2, 16'h7001);
    intr_req = 1'b1;
    run(0, 16'hABCD, c_h, c_w, a_w, e_w);
    intr_req = 1'b0;
    checks++; if (pc !== 12'd3) begin errors++; $display("FAIL intr_pc: got %0d want 3", pc); end
`ifdef MANO_INTR_EN
    checks++; if (mem_arr[0] !== 16'h0002) begin errors++; $display("FAIL intr_saved_pc: got %h want 0002", mem_arr[0]); end
    checks++; if (c_h != 14) begin errors++; $display("FAIL intr_cycles: got %0d want 14", c_h); end
`else
    checks++; if (mem_arr[0] !== 16'hF080) begin errors++; $display("FAIL intr_mem0: got %h want f080", mem_arr[0]); end
    checks++; if (c_h != 10) begin errors++; $display("FAIL intr_cycles: got %0d want 10", c_h); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_lda_add();
    test_indirect();
    test_isz_bsa();
    test_regref();
    test_intr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
